// File: rtl/ysyx_22041752_mem_arbiter_pkg.sv
// rtl/ysyx_22041752_mem_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package ysyx_22041752_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_IC    = 2'd0,
        OWN_DC_RD = 2'd1,
        OWN_DC_WR = 2'd2
    } owner_t;

    localparam int DEF_BURST_LEN = 4;

    function automatic logic is_read(input owner_t own);
        return own != OWN_DC_WR;
    endfunction

endpackage

// File: rtl/ysyx_22041752_mem_arbiter_rr_arb2.sv
// rtl/ysyx_22041752_mem_arbiter_rr_arb2.sv - two-way round-robin arbiter (bit 0 = ICache, bit 1 = DCache)
module ysyx_22041752_mem_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    input  logic [1:0] upd,
    output logic [1:0] gnt
);

    // 1 = DCache was granted last, 0 = ICache was granted last
    logic rr_last;

    // on a tie the requester not granted last wins; a lone request always wins
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr_last ? 2'b01 : 2'b10;
        end
    end

    // remember who won, only when the burst is actually accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b0;
        end else if (en) begin
            rr_last <= upd[1];
        end
    end

endmodule

// File: rtl/ysyx_22041752_mem_arbiter.sv
// rtl/ysyx_22041752_mem_arbiter.sv - shares one memory port between ICache refill and DCache refill/writeback
module ysyx_22041752_mem_arbiter
    import ysyx_22041752_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 64,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_rd_req,
    input  logic [ADDR_WD-1:0]   ic_rd_addr,
    output logic                 ic_rd_gnt,
    output logic                 ic_rd_valid,
    output logic                 ic_rd_last,
    input  logic                 dc_rd_req,
    input  logic [ADDR_WD-1:0]   dc_rd_addr,
    output logic                 dc_rd_gnt,
    output logic                 dc_rd_valid,
    output logic                 dc_rd_last,
    output logic [DATA_WD-1:0]   rd_data,
    input  logic                 dc_wr_req,
    input  logic [ADDR_WD-1:0]   dc_wr_addr,
    input  logic [DATA_WD-1:0]   dc_wr_data,
    input  logic [DATA_WD/8-1:0] dc_wr_strb,
    output logic                 dc_wr_ack,
    output logic                 dc_wr_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_WD-1:0]   mem_addr,
    input  logic                 mem_ready,
    output logic                 mem_wvalid,
    output logic [DATA_WD-1:0]   mem_wdata,
    output logic [DATA_WD/8-1:0] mem_wstrb,
    output logic                 mem_wlast,
    input  logic                 mem_wready,
    input  logic                 mem_rvalid,
    input  logic [DATA_WD-1:0]   mem_rdata,
    input  logic                 mem_rlast,
    input  logic                 mem_bvalid
);

    localparam int CNT_WD = $clog2(BURST_LEN);

    state_t            state;
    owner_t            owner;
    logic [CNT_WD-1:0] cnt;
    logic [1:0]        rd_gnt;
    logic              addr_hs;
    logic              rr_en;
    logic              in_rd;
    logic              last_beat;

    assign addr_hs   = (state == ST_ADDR) && mem_ready;
    assign rr_en     = addr_hs && is_read(owner);
    assign in_rd     = (state == ST_RDATA);
    assign last_beat = (cnt == CNT_WD'(BURST_LEN - 1));

    ysyx_22041752_mem_arbiter_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   ({dc_rd_req, ic_rd_req}),
        .en    (rr_en),
        .upd   ((owner == OWN_DC_RD) ? 2'b10 : 2'b01),
        .gnt   (rd_gnt)
    );

    // burst sequencer: arbitrate in IDLE, then own the port until the burst finishes
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_IC;
            cnt      <= '0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // writeback goes ahead of any refill so a victim line leaves before its set is refilled
                    if (dc_wr_req) begin
                        owner    <= OWN_DC_WR;
                        mem_addr <= dc_wr_addr;
                        mem_we   <= 1'b1;
                        state    <= ST_ADDR;
                    end else if (rd_gnt != 2'b00) begin
                        owner    <= rd_gnt[1] ? OWN_DC_RD : OWN_IC;
                        mem_addr <= rd_gnt[1] ? dc_rd_addr : ic_rd_addr;
                        mem_we   <= 1'b0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_ready) begin
                        state <= mem_we ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (mem_rvalid && mem_rlast) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (mem_wready) begin
                        cnt <= cnt + CNT_WD'(1);
                        if (last_beat) begin
                            state <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (mem_bvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // response steering: only the current owner ever sees beats or handshakes
    always_comb begin
        mem_req     = (state == ST_ADDR);
        ic_rd_gnt   = addr_hs && (owner == OWN_IC);
        dc_rd_gnt   = addr_hs && (owner == OWN_DC_RD);
        ic_rd_valid = in_rd && (owner == OWN_IC) && mem_rvalid;
        dc_rd_valid = in_rd && (owner == OWN_DC_RD) && mem_rvalid;
        ic_rd_last  = ic_rd_valid && mem_rlast;
        dc_rd_last  = dc_rd_valid && mem_rlast;
        rd_data     = in_rd ? mem_rdata : '0;
        mem_wvalid  = (state == ST_WDATA);
        mem_wdata   = mem_wvalid ? dc_wr_data : '0;
        mem_wstrb   = mem_wvalid ? dc_wr_strb : '0;
        mem_wlast   = mem_wvalid && last_beat;
        dc_wr_ack   = mem_wvalid && mem_wready;
        dc_wr_done  = (state == ST_WRESP) && mem_bvalid;
    end

endmodule

// File: tb/tb_ysyx_22041752_mem_arbiter.sv
// tb/tb_ysyx_22041752_mem_arbiter.sv - self-checking bench for the memory port arbiter
module tb_ysyx_22041752_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_rd_req, dc_rd_req, dc_wr_req;
    logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic        ic_rd_gnt, ic_rd_valid, ic_rd_last;
    logic        dc_rd_gnt, dc_rd_valid, dc_rd_last;
    logic [63:0] rd_data;
    logic [63:0] dc_wr_data;
    logic [7:0]  dc_wr_strb;
    logic        dc_wr_ack, dc_wr_done;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_wvalid, mem_wlast;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_wready, mem_rvalid, mem_rlast, mem_bvalid;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    bit rr_ref = 1'b0;
    bit wr_toggle = 1'b0;

    always #5 clk = ~clk;

    ysyx_22041752_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_gnt(ic_rd_gnt),
        .ic_rd_valid(ic_rd_valid), .ic_rd_last(ic_rd_last),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_gnt(dc_rd_gnt),
        .dc_rd_valid(dc_rd_valid), .dc_rd_last(dc_rd_last),
        .rd_data(rd_data),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .dc_wr_strb(dc_wr_strb), .dc_wr_ack(dc_wr_ack), .dc_wr_done(dc_wr_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_wlast(mem_wlast), .mem_wready(mem_wready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .mem_bvalid(mem_bvalid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop(input int own);
        if (own == 0) ic_rd_req = 1'b0;
        else if (own == 1) dc_rd_req = 1'b0;
        else dc_wr_req = 1'b0;
    endtask

    // leaves the caller at a falling edge with mem_req seen (or the bound expired)
    task automatic wait_req(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = mem_req;
        chk("req_seen", mem_req, 1);
    endtask

    // play the memory side of one burst owned by 'own' (0 IC read, 1 DC read, 2 DC write)
    task automatic serve(input int own, input int d);
        logic [31:0] ea;
        logic [63:0] wd[4];
        logic [63:0] rdv;
        int n, beats, k;
        bit ok, rv;
        ea = (own == 0) ? ic_rd_addr : (own == 1) ? dc_rd_addr : dc_wr_addr;
        for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
        if (own == 2) dc_wr_data = wd[0];
        wait_req(ok);
        if (!ok) begin
            drop(own);
            return;
        end
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", mem_we, own == 2);
        for (int i = 0; i <= d; i++) begin
            @(posedge clk); #1;
            mem_ready = (i == d);
            @(negedge clk);
            chk("req_hold", mem_req, 1);
            chk("ic_gnt", ic_rd_gnt, (own == 0) && (i == d));
            chk("dc_gnt", dc_rd_gnt, (own == 1) && (i == d));
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if (own != 2) begin
            drop(own);
            beats = 0;
            n = 0;
            while (beats < 4 && n < 64) begin
                rv = ($urandom_range(0, 2) != 0);
                rdv = {$urandom, $urandom};
                mem_rvalid = rv;
                mem_rdata = rdv;
                mem_rlast = rv && (beats == 3);
                @(negedge clk);
                chk("ic_valid", ic_rd_valid, (own == 0) && rv);
                chk("dc_valid", dc_rd_valid, (own == 1) && rv);
                chk("ic_last", ic_rd_last, (own == 0) && rv && (beats == 3));
                chk("dc_last", dc_rd_last, (own == 1) && rv && (beats == 3));
                if (rv) chk("rd_data", rd_data, rdv);
                if (rv) beats++;
                n++;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rlast = 1'b0;
            end
            chk("rd_beats", beats, 4);
        end else begin
            beats = 0;
            k = 0;
            n = 0;
            while (beats < 4 && n < 64) begin
                mem_wready = wr_toggle ? (k % 2 == 0) : 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("wvalid", mem_wvalid, 1);
                chk("wdata", mem_wdata, wd[beats]);
                chk("wstrb", mem_wstrb, dc_wr_strb);
                chk("wlast", mem_wlast, beats == 3);
                chk("wr_ack", dc_wr_ack, mem_wready);
                if (mem_wready) beats++;
                k++;
                n++;
                @(posedge clk); #1;
                if (beats < 4) dc_wr_data = wd[beats];
            end
            chk("wr_beats", beats, 4);
            for (int i = 0; i <= d; i++) begin
                mem_wready = 1'b1;
                mem_bvalid = (i == d);
                @(negedge clk);
                chk("ack_after_last", dc_wr_ack, 0);
                chk("wvalid_resp", mem_wvalid, 0);
                chk("wr_done", dc_wr_done, i == d);
                @(posedge clk); #1;
            end
            mem_bvalid = 1'b0;
            mem_wready = 1'b0;
            dc_wr_req = 1'b0;
        end
    endtask

    // reference order: writeback first, then round-robin among reads, lone request wins
    task automatic run_all(input int d);
        int pick;
        int guard = 0;
        while ((ic_rd_req || dc_rd_req || dc_wr_req) && guard < 8) begin
            if (dc_wr_req) pick = 2;
            else if (ic_rd_req && dc_rd_req) pick = rr_ref ? 0 : 1;
            else pick = ic_rd_req ? 0 : 1;
            serve(pick, (d < 0) ? $urandom_range(0, 3) : d);
            if (pick != 2) rr_ref = (pick == 1);
            guard++;
        end
    endtask

    initial begin
        bit ok;
        reset = 1'b1;
        {ic_rd_req, dc_rd_req, dc_wr_req} = '0;
        ic_rd_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0;
        dc_wr_data = '0; dc_wr_strb = '0;
        {mem_ready, mem_wready, mem_rvalid, mem_rlast, mem_bvalid} = '0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wvalid", mem_wvalid, 0);
        chk("rst_valids", {ic_rd_valid, dc_rd_valid, ic_rd_gnt, dc_rd_gnt}, 0);
        chk("rst_wr", {dc_wr_ack, dc_wr_done}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // lone ICache refill at 0x8000_0000
        ic_rd_addr = 32'h8000_0000;
        ic_rd_req = 1'b1;
        run_all(2);

        // simultaneous ICache/DCache refills, twice
        for (int r = 0; r < 2; r++) begin
            ic_rd_addr = $urandom & 32'hffff_ffe0;
            dc_rd_addr = $urandom & 32'hffff_ffe0;
            ic_rd_req = 1'b1;
            dc_rd_req = 1'b1;
            run_all(-1);
        end

        // writeback plus both refills together
        dc_wr_addr = $urandom & 32'hffff_ffe0;
        dc_wr_strb = 8'($urandom);
        ic_rd_req = 1'b1; dc_rd_req = 1'b1; dc_wr_req = 1'b1;
        run_all(-1);

        // writeback with wready toggling 1,0,1,0
        wr_toggle = 1'b1;
        dc_wr_strb = 8'hff;
        dc_wr_req = 1'b1;
        run_all(1);
        wr_toggle = 1'b0;

        // random request mixes
        for (int r = 0; r < 6; r++) begin
            ic_rd_addr = $urandom;
            dc_rd_addr = $urandom;
            dc_wr_addr = $urandom;
            dc_wr_strb = 8'($urandom);
            ic_rd_req = 1'($urandom_range(0, 1));
            dc_rd_req = 1'($urandom_range(0, 1));
            dc_wr_req = 1'($urandom_range(0, 1));
            run_all(-1);
        end

        // reset in the middle of a read burst
        ic_rd_addr = 32'h1234_5600;
        ic_rd_req = 1'b1;
        wait_req(ok);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        ic_rd_req = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 64'h1111;
        @(negedge clk);
        chk("beat1_valid", ic_rd_valid, 1);
        @(posedge clk); #1;
        mem_rdata = 64'h2222;
        reset = 1'b1;
        @(negedge clk);
        chk("beat2_valid", ic_rd_valid, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_valid", {ic_rd_valid, ic_rd_last, dc_rd_valid}, 0);
        chk("postrst_rd_data", rd_data, 0);
        chk("postrst_mem_req", mem_req, 0);
        chk("postrst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        rr_ref = 1'b0;
        ic_rd_addr = $urandom & 32'hffff_ffe0;
        dc_rd_addr = $urandom & 32'hffff_ffe0;
        ic_rd_req = 1'b1;
        dc_rd_req = 1'b1;
        run_all(-1);

        // stray read beats and write responses while idle
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rlast = 1'b1;
            mem_bvalid = 1'b1;
            @(negedge clk);
            chk("stray_valid", {ic_rd_valid, dc_rd_valid, ic_rd_last, dc_rd_last}, 0);
            chk("stray_done", dc_wr_done, 0);
            chk("stray_req", mem_req, 0);
            @(posedge clk); #1;
        end
        {mem_rvalid, mem_rlast, mem_bvalid} = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
